// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryption core: ROUNDS_PER_CYCLE rounds per clock, key schedule on the fly.
// Optional block counter output blk_cnt when AES_BLK_COUNT_EN is defined.
module aes_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_text,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text
`ifdef AES_BLK_COUNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  generate
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
      $fatal(1, "aes_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, aa, bb;
    acc = 8'h00;
    aa  = a;
    bb  = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) acc = acc ^ aa;
      aa = xtime(aa);
      bb = {1'b0, bb[7:1]};
    end
    return acc;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, inv;
    p   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Byte 4*c+r of the 128-bit vector is state row r, column c.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] sr, mc;
    logic [7:0]   a0, a1, a2, a3;
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    mc = sr;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = sr[127-32*c -: 8];
        a1 = sr[119-32*c -: 8];
        a2 = sr[111-32*c -: 8];
        a3 = sr[103-32*c -: 8];
        mc[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        mc[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        mc[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        mc[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    return mc ^ rk;
  endfunction

  state_t       r_fsm, w_fsm_nxt;
  logic         r_ready_en;
  logic [127:0] r_state, r_key, r_out_text;
  logic [3:0]   r_round;
  logic [127:0] w_state [0:ROUNDS_PER_CYCLE];
  logic [127:0] w_key   [0:ROUNDS_PER_CYCLE];
  logic         w_last, w_accept, w_take;

  assign in_ready  = (r_fsm == IDLE) && r_ready_en;
  assign out_valid = (r_fsm == DONE);
  assign out_text  = r_out_text;
  assign w_accept  = in_valid && in_ready;
  assign w_take    = out_valid && out_ready;
  assign w_last    = ({1'b0, r_round} + 5'(ROUNDS_PER_CYCLE)) > 5'd10;

  // Unrolled chain of rounds; round numbers run r_round .. r_round+ROUNDS_PER_CYCLE-1.
  always_comb begin
    w_state[0] = r_state;
    w_key[0]   = r_key;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      w_key[i+1]   = key_step(w_key[i], rcon_of(r_round + 4'(i)));
      w_state[i+1] = aes_round(w_state[i], w_key[i+1], (r_round + 4'(i)) == 4'd10);
    end
  end

  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (w_accept) w_fsm_nxt = RUN;
      RUN:     if (w_last)   w_fsm_nxt = DONE;
      DONE:    if (w_take)   w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= IDLE;
      r_ready_en <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_fsm      <= w_fsm_nxt;
      r_ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= '0;
      r_key      <= '0;
      r_round    <= '0;
      r_out_text <= '0;
    end else if (w_accept) begin
      r_state <= in_text ^ in_key;
      r_key   <= in_key;
      r_round <= 4'd1;
    end else if (r_fsm == RUN) begin
      r_state <= w_state[ROUNDS_PER_CYCLE];
      r_key   <= w_key[ROUNDS_PER_CYCLE];
      r_round <= r_round + 4'(ROUNDS_PER_CYCLE);
      if (w_last) r_out_text <= w_state[ROUNDS_PER_CYCLE];
    end
  end

`ifdef AES_BLK_COUNT_EN
  logic [31:0] r_blk_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_blk_cnt <= '0;
    else if (w_take) r_blk_cnt <= r_blk_cnt + 32'd1;
  end

  assign blk_cnt = r_blk_cnt;
`endif

endmodule

// File: doc/aes_iter_core.md
AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, giving AES-128 rounds evaluated per clock; legal values are 1, 2, 5 and 10.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: key and plaintext are presented.
REQ-005 SHALL have port in_ready, output, 1 bit: the core accepts a block.
REQ-006 SHALL have port in_key, input, 128 bits: cipher key, byte 0 in bits [127:120].
REQ-007 SHALL have port in_text, input, 128 bits: plaintext, byte 0 in bits [127:120].
REQ-008 SHALL have port out_valid, output, 1 bit: ciphertext is available.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the ciphertext.
REQ-010 SHALL have port out_text, output, 128 bits: ciphertext, same byte order as in_text.

Function
REQ-011 SHALL implement FIPS-197 AES-128 encryption only, computing round keys on the fly with no stored key schedule.
REQ-012 SHALL use an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE, so there is no input buffering.
REQ-014 SHALL treat in_valid&&in_ready at a rising edge as accept: state <= in_text^in_key, round key <= in_key, round counter <= 1, go to RUN.
REQ-015 SHALL, in RUN, apply ROUNDS_PER_CYCLE consecutive rounds per clock, updating the round key and Rcon per round.
REQ-016 SHALL make round 10 omit MixColumns.
REQ-017 SHALL advance the round counter by ROUNDS_PER_CYCLE each cycle.
REQ-018 SHALL go to DONE after round 10 completes.
REQ-019 SHALL assert out_valid exactly 10/ROUNDS_PER_CYCLE clocks after the accept edge: 10, 5, 2 or 1 cycles.
REQ-020 SHALL hold out_text stable and out_valid high in DONE until out_valid&&out_ready.
REQ-021 SHALL, on that handshake, go to IDLE with in_ready=1 on the next cycle; accept-in-same-cycle bypass is not provided.
REQ-022 SHALL ignore out_ready outside DONE and ignore in_valid outside IDLE; in_key and in_text are sampled only at accept.
REQ-023 SHALL keep out_text holding the last ciphertext after the handshake, undefined only before the first completion.
REQ-024 SHALL fail elaboration when ROUNDS_PER_CYCLE is not 1, 2, 5 or 10.
REQ-025 SHALL give sustained throughput of one block per 10/ROUNDS_PER_CYCLE+2 cycles with out_ready held high.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force FSM=IDLE, in_ready=0, out_valid=0, out_text=0, round counter=0 and internal state/key=0.
REQ-027 SHALL set in_ready=1 from the first rising edge after rst_n deasserts.
REQ-028 SHALL, when reset is asserted in RUN or DONE, abort the block with no out_valid for it after release.

Configuration
REQ-029 SHALL, when macro AES_BLK_COUNT_EN is defined, add output blk_cnt, 32 bits.
REQ-030 SHALL reset blk_cnt to 0 and increment it by 1 on each out_valid&&out_ready, wrapping from 0xFFFFFFFF to 0.
REQ-031 SHALL, when AES_BLK_COUNT_EN is undefined, omit the blk_cnt port and counter logic, with all other behaviour identical.

Verification
REQ-032 SHALL cover FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, text 3243f6a8885a308d313198a2e0370734 -> out_text 3925841d02dc09fbdc118597196a0b32, out_valid 10 cycles after accept at ROUNDS_PER_CYCLE=1.
REQ-033 SHALL cover key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a at ROUNDS_PER_CYCLE=2, 5 and 10, with latency 5, 2 and 1 respectively.
REQ-034 SHALL cover key 5468617473206d79204b756e67204675, text 54776f204f6e65204e696e652054776f, out_ready held low 20 cycles -> out_text 29c3505f571420f6402299b31a02d73a stable throughout and in_ready=0.
REQ-035 SHALL cover in_valid pulsed with new data during RUN -> ignored, result still matches the first block.
REQ-036 SHALL cover rst_n asserted at round 4 of a block -> out_valid stays 0; a next block accepted after release is correct.
REQ-037 SHALL cover AES_BLK_COUNT_EN defined, 3 back-to-back blocks with out_ready=1 -> blk_cnt=3, and blk_cnt forced to 0xFFFFFFFF then one block -> blk_cnt=0.
